// File: rtl/operand_fwd_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | operand_fwd_pkg                                                  |
// | Shared widths, pipeline slot record and the slot hit predicate.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package operand_fwd_pkg;

  localparam int DATA_W  = 16;
  localparam int RADDR_W = 4;

  typedef struct packed {
    logic               valid;
    logic               we;
    logic               is_load;
    logic [RADDR_W-1:0] dst_addr;
  } slot_ctrl_t;

  typedef struct packed {
    slot_ctrl_t         ctl;
    logic [DATA_W-1:0]  value;
  } slot_t;

  localparam slot_ctrl_t c_BUBBLE_CTRL = '0;
  localparam slot_t      c_BUBBLE_SLOT = '0;

  // R0 is hard-wired zero, so it never matches a producer
  function automatic logic slot_hit(input slot_ctrl_t s,
                                    input logic [RADDR_W-1:0] addr,
                                    input logic re);
    return s.valid && s.we && (s.dst_addr == addr) && (addr != '0) && re;
  endfunction

endpackage
`default_nettype wire

// File: rtl/operand_fwd_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | operand_fwd_if                                                   |
// | Decode/issue/EX/MEM/WB bundle; perf counters with                |
// | OPERAND_FWD_PERF_EN.                                             |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface operand_fwd_if;

  logic [operand_fwd_pkg::RADDR_W-1:0] id_p0_addr;
  logic [operand_fwd_pkg::RADDR_W-1:0] id_p1_addr;
  logic                                id_re0;
  logic                                id_re1;
  logic [operand_fwd_pkg::DATA_W-1:0]  rf_p0;
  logic [operand_fwd_pkg::DATA_W-1:0]  rf_p1;
  logic                                iss_valid;
  logic                                iss_we;
  logic                                iss_is_load;
  logic [operand_fwd_pkg::RADDR_W-1:0] iss_dst_addr;
  logic [operand_fwd_pkg::DATA_W-1:0]  ex_result;
  logic [operand_fwd_pkg::DATA_W-1:0]  mem_result;
  logic                                flush;
  logic [operand_fwd_pkg::DATA_W-1:0]  op0;
  logic [operand_fwd_pkg::DATA_W-1:0]  op1;
  logic                                stall;
  logic                                wb_we;
  logic [operand_fwd_pkg::RADDR_W-1:0] wb_dst_addr;
  logic [operand_fwd_pkg::DATA_W-1:0]  wb_dst;
`ifdef OPERAND_FWD_PERF_EN
  logic [15:0]                         stall_cnt;
  logic [15:0]                         fwd_cnt;

  modport master (
    output id_p0_addr, id_p1_addr, id_re0, id_re1, rf_p0, rf_p1,
           iss_valid, iss_we, iss_is_load, iss_dst_addr,
           ex_result, mem_result, flush,
    input  op0, op1, stall, wb_we, wb_dst_addr, wb_dst, stall_cnt, fwd_cnt
  );

  modport slave (
    input  id_p0_addr, id_p1_addr, id_re0, id_re1, rf_p0, rf_p1,
           iss_valid, iss_we, iss_is_load, iss_dst_addr,
           ex_result, mem_result, flush,
    output op0, op1, stall, wb_we, wb_dst_addr, wb_dst, stall_cnt, fwd_cnt
  );
`else
  modport master (
    output id_p0_addr, id_p1_addr, id_re0, id_re1, rf_p0, rf_p1,
           iss_valid, iss_we, iss_is_load, iss_dst_addr,
           ex_result, mem_result, flush,
    input  op0, op1, stall, wb_we, wb_dst_addr, wb_dst
  );

  modport slave (
    input  id_p0_addr, id_p1_addr, id_re0, id_re1, rf_p0, rf_p1,
           iss_valid, iss_we, iss_is_load, iss_dst_addr,
           ex_result, mem_result, flush,
    output op0, op1, stall, wb_we, wb_dst_addr, wb_dst
  );
`endif

endinterface
`default_nettype wire

// File: rtl/operand_fwd_mux.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fwd_mux                                                          |
// | One operand: EX/MEM hit compare and priority select over RF.     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module fwd_mux
  import operand_fwd_pkg::*;
(
  input  logic [RADDR_W-1:0] i_addr,
  input  logic               i_re,
  input  slot_ctrl_t         i_ex,
  input  slot_t              i_mem,
  input  logic [DATA_W-1:0]  i_ex_result,
  input  logic [DATA_W-1:0]  i_mem_result,
  input  logic [DATA_W-1:0]  i_rf,
  output logic [DATA_W-1:0]  o_op,
  output logic               o_ex_load_hit,
  output logic               o_fwd
);

  logic w_ex_hit;
  logic w_mem_hit;

  assign w_ex_hit  = slot_hit(i_ex, i_addr, i_re);
  assign w_mem_hit = slot_hit(i_mem.ctl, i_addr, i_re);

  // A load in EX has no data yet; the caller stalls on o_ex_load_hit
  assign o_ex_load_hit = w_ex_hit && i_ex.is_load;

  always_comb begin
    o_op  = i_rf;
    o_fwd = 1'b0;
    if (w_ex_hit && !i_ex.is_load) begin
      o_op  = i_ex_result;
      o_fwd = 1'b1;
    end else if (w_mem_hit) begin
      o_op  = i_mem.ctl.is_load ? i_mem_result : i_mem.value;
      o_fwd = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/operand_fwd.sv
`default_nettype none
// +------------------------------------------------------------------+
// | operand_fwd                                                      |
// | EX/MEM/WB tracking, operand bypass and load-use stall.           |
// | OPERAND_FWD_PERF_EN adds stall_cnt / fwd_cnt.                    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module operand_fwd
  import operand_fwd_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  operand_fwd_if.slave bus
);

  slot_ctrl_t        r_ex;
  slot_t             r_mem;
  slot_t             r_wb;

  logic [DATA_W-1:0] w_op0;
  logic [DATA_W-1:0] w_op1;
  logic              w_ld_hit0;
  logic              w_ld_hit1;
  logic              w_fwd0;
  logic              w_fwd1;
  logic              w_stall;

  fwd_mux u_mux0 (
    .i_addr        (bus.id_p0_addr),
    .i_re          (bus.id_re0),
    .i_ex          (r_ex),
    .i_mem         (r_mem),
    .i_ex_result   (bus.ex_result),
    .i_mem_result  (bus.mem_result),
    .i_rf          (bus.rf_p0),
    .o_op          (w_op0),
    .o_ex_load_hit (w_ld_hit0),
    .o_fwd         (w_fwd0)
  );

  fwd_mux u_mux1 (
    .i_addr        (bus.id_p1_addr),
    .i_re          (bus.id_re1),
    .i_ex          (r_ex),
    .i_mem         (r_mem),
    .i_ex_result   (bus.ex_result),
    .i_mem_result  (bus.mem_result),
    .i_rf          (bus.rf_p1),
    .o_op          (w_op1),
    .o_ex_load_hit (w_ld_hit1),
    .o_fwd         (w_fwd1)
  );

  // A flush removes the load from EX, so there is nothing to wait for
  assign w_stall = (w_ld_hit0 || w_ld_hit1) && !bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex  <= c_BUBBLE_CTRL;
      r_mem <= c_BUBBLE_SLOT;
      r_wb  <= c_BUBBLE_SLOT;
    end else begin
      if (bus.flush || w_stall) begin
        r_ex <= c_BUBBLE_CTRL;
      end else begin
        r_ex <= {bus.iss_valid, bus.iss_we, bus.iss_is_load, bus.iss_dst_addr};
      end

      if (bus.flush) begin
        r_mem <= c_BUBBLE_SLOT;
      end else begin
        r_mem.ctl   <= r_ex;
        r_mem.value <= bus.ex_result;
      end

      r_wb.ctl   <= r_mem.ctl;
      r_wb.value <= r_mem.ctl.is_load ? bus.mem_result : r_mem.value;
    end
  end

  assign bus.op0         = w_op0;
  assign bus.op1         = w_op1;
  assign bus.stall       = w_stall;
  assign bus.wb_we       = r_wb.ctl.valid && r_wb.ctl.we && (r_wb.ctl.dst_addr != '0);
  assign bus.wb_dst_addr = r_wb.ctl.dst_addr;
  assign bus.wb_dst      = r_wb.value;

`ifdef OPERAND_FWD_PERF_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_fwd_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_fwd_cnt   <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
      if ((w_fwd0 || w_fwd1) && (r_fwd_cnt != 16'hFFFF)) begin
        r_fwd_cnt <= r_fwd_cnt + 16'd1;
      end
    end
  end

  assign bus.stall_cnt = r_stall_cnt;
  assign bus.fwd_cnt   = r_fwd_cnt;
`else
  logic w_unused_fwd;
  assign w_unused_fwd = w_fwd0 ^ w_fwd1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_operand_fwd.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_operand_fwd                                                   |
// | Directed self-checking bench for operand_fwd.                    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_operand_fwd;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  operand_fwd_if bus ();

  operand_fwd dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.id_p0_addr   = 4'd0;
    bus.id_p1_addr   = 4'd0;
    bus.id_re0       = 1'b0;
    bus.id_re1       = 1'b0;
    bus.rf_p0        = 16'h00A0;
    bus.rf_p1        = 16'h00B0;
    bus.iss_valid    = 1'b0;
    bus.iss_we       = 1'b0;
    bus.iss_is_load  = 1'b0;
    bus.iss_dst_addr = 4'd0;
    bus.ex_result    = 16'h0000;
    bus.mem_result   = 16'h0000;
    bus.flush        = 1'b0;
  endtask

  task automatic issue(input logic ld, input logic [3:0] dst);
    bus.iss_valid    = 1'b1;
    bus.iss_we       = 1'b1;
    bus.iss_is_load  = ld;
    bus.iss_dst_addr = dst;
  endtask

  // Advance to just after the next edge with all inputs idle
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #12;
    chk("rst_stall", {15'd0, bus.stall}, 16'd0);
    chk("rst_wb_we", {15'd0, bus.wb_we}, 16'd0);
    chk("rst_wb_dst", bus.wb_dst, 16'h0000);
    chk("rst_wb_addr", {12'd0, bus.wb_dst_addr}, 16'd0);
`ifdef OPERAND_FWD_PERF_EN
    chk("rst_stall_cnt", bus.stall_cnt, 16'd0);
    chk("rst_fwd_cnt", bus.fwd_cnt, 16'd0);
`endif
    #1 rst_n = 1'b1;
    tick();

    // ALU result forwards from EX with no stall
    issue(1'b0, 4'd3);
    #4 chk("add_issue_stall", {15'd0, bus.stall}, 16'd0);
    tick();
    bus.id_p0_addr = 4'd3; bus.id_re0 = 1'b1;
    bus.id_p1_addr = 4'd3; bus.ex_result = 16'h1234;
    #4 chk("ex_fwd_op0", bus.op0, 16'h1234);
    chk("ex_fwd_stall", {15'd0, bus.stall}, 16'd0);
    chk("re1_off_rf", bus.op1, 16'h00B0);
    tick();
    bus.id_p1_addr = 4'd3; bus.id_re1 = 1'b1;
    #4 chk("mem_fwd_op1", bus.op1, 16'h1234);
    tick();
    #4 chk("add_wb_we", {15'd0, bus.wb_we}, 16'd1);
    chk("add_wb_addr", {12'd0, bus.wb_dst_addr}, 16'd3);
    chk("add_wb_dst", bus.wb_dst, 16'h1234);
    tick();

    // Load-use: one stall cycle, then load data forwarded from MEM
    issue(1'b1, 4'd5);
    tick();
    bus.id_p1_addr = 4'd5; bus.id_re1 = 1'b1;
    issue(1'b0, 4'd6);
    #4 chk("lu_stall", {15'd0, bus.stall}, 16'd1);
    tick();
    bus.id_p1_addr = 4'd5; bus.id_re1 = 1'b1; bus.mem_result = 16'hBEEF;
    #4 chk("lu_op1", bus.op1, 16'hBEEF);
    chk("lu_stall_gone", {15'd0, bus.stall}, 16'd0);
    tick();
    #4 chk("lw_wb_we", {15'd0, bus.wb_we}, 16'd1);
    chk("lw_wb_addr", {12'd0, bus.wb_dst_addr}, 16'd5);
    chk("lw_wb_dst", bus.wb_dst, 16'hBEEF);
    tick();
    #4 chk("stalled_iss_dropped", {15'd0, bus.wb_we}, 16'd0);
    tick();

    // R0 is never forwarded nor written
    issue(1'b0, 4'd0);
    tick();
    bus.id_p0_addr = 4'd0; bus.id_re0 = 1'b1;
    bus.rf_p0 = 16'h0000; bus.ex_result = 16'hFFFF;
    #4 chk("r0_op0", bus.op0, 16'h0000);
    tick();
    bus.ex_result = 16'h0000;
    tick();
    #4 chk("r0_wb_we", {15'd0, bus.wb_we}, 16'd0);
    tick();

    // Younger producer in EX beats older one in MEM
    issue(1'b0, 4'd2);
    tick();
    bus.ex_result = 16'h0001;
    issue(1'b0, 4'd2);
    tick();
    bus.id_p0_addr = 4'd2; bus.id_re0 = 1'b1; bus.ex_result = 16'h0002;
    #4 chk("ex_beats_mem", bus.op0, 16'h0002);
    tick();
    bus.id_p0_addr = 4'd2; bus.id_re0 = 1'b1;
    #4 chk("mem_r2b", bus.op0, 16'h0002);
    chk("wb_r2a", bus.wb_dst, 16'h0001);
    tick();
    #4 chk("wb_r2b", bus.wb_dst, 16'h0002);
    tick();

    // Flush coincident with load-use
    issue(1'b1, 4'd7);
    tick();
    bus.id_p0_addr = 4'd7; bus.id_re0 = 1'b1; bus.flush = 1'b1;
    issue(1'b0, 4'd9);
    #4 chk("flush_no_stall", {15'd0, bus.stall}, 16'd0);
    tick();
    bus.id_p0_addr = 4'd7; bus.id_re0 = 1'b1;
    #4 chk("flush_ex_bubble", {15'd0, bus.stall}, 16'd0);
    tick();
    bus.mem_result = 16'h7777;
    #4 chk("flush_lw_killed", {15'd0, bus.wb_we}, 16'd0);
    tick();
    #4 chk("flush_iss_killed", {15'd0, bus.wb_we}, 16'd0);
    tick();

    // Reset while stalled with three valid slots
    issue(1'b0, 4'd1);
    tick();
    bus.ex_result = 16'h0011;
    issue(1'b0, 4'd2);
    tick();
    bus.ex_result = 16'h0022;
    issue(1'b1, 4'd3);
    tick();
    bus.id_p0_addr = 4'd3; bus.id_re0 = 1'b1;
    #4 chk("pre_rst_stall", {15'd0, bus.stall}, 16'd1);
    chk("pre_rst_wb_we", {15'd0, bus.wb_we}, 16'd1);
    chk("pre_rst_wb_dst", bus.wb_dst, 16'h0011);
    #1 rst_n = 1'b0;
    idle();
    bus.id_p0_addr = 4'd3; bus.id_re0 = 1'b1;
    #1 chk("mid_rst_stall", {15'd0, bus.stall}, 16'd0);
    chk("mid_rst_wb_we", {15'd0, bus.wb_we}, 16'd0);
    chk("mid_rst_wb_dst", bus.wb_dst, 16'h0000);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.mem_result = 16'h3333;
      #4 chk($sformatf("post_rst_wb_we_%0d", i), {15'd0, bus.wb_we}, 16'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
